// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-path constants and types, also used by the decode and branch units.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT  = '0;             // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEFAULT  = '0;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] TARGET_ALIGN_MASK = 32'hFFFF_FFFC;

  // Which source loads the PC on the coming edge, highest priority first.
  typedef enum logic [2:0] {
    PC_SEL_RESET,
    PC_SEL_REDIRECT,
    PC_SEL_HOLD,
    PC_SEL_JUMP,
    PC_SEL_SEQ
  } pc_sel_e;

  // Word-align a control-transfer target.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return target & TARGET_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id.sv
// IF/ID pipeline register: holds instr, pc_plus4 and valid with load/hold/flush.
module if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Flush wins over load; neither asserted means hold.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_WORD;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // Synchronous active-low reset clears to a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, priority next-PC mux, IF/ID register and fetch counter.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  pc_sel_e     pc_sel;
  logic        ifid_load;
  logic        ifid_flush;

  assign pc_plus4 = pc_q + PC_STEP;

  // Select the next-PC source by fixed priority.
  always_comb begin
    if (!reset)           pc_sel = PC_SEL_RESET;
    else if (ex_redirect) pc_sel = PC_SEL_REDIRECT;
    else if (stall)       pc_sel = PC_SEL_HOLD;
    else if (id_jump)     pc_sel = PC_SEL_JUMP;
    else                  pc_sel = PC_SEL_SEQ;
  end

  // Next PC, IF/ID controls and counter update from the selected source.
  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    unique case (pc_sel)
      PC_SEL_RESET:    pc_d = RESET_PC;
      PC_SEL_REDIRECT: begin
        pc_d       = align_target(ex_target);
        ifid_flush = 1'b1;
      end
      PC_SEL_HOLD:     pc_d = pc_q;
      PC_SEL_JUMP:     begin
        pc_d       = align_target(id_jump_target);
        ifid_flush = 1'b1;
      end
      PC_SEL_SEQ:      begin
        pc_d          = pc_plus4;
        ifid_load     = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      default:         pc_d = pc_q;
    endcase
  end

  // PC and counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_register #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (imem_instr),
    .pc_plus4_in (pc_plus4),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed steps then random traffic
// against a transaction-level model of the fetch rules.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        id_jump = 1'b0;
  logic [31:0] id_jump_target = '0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        mem_x = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign imem_instr = mem_x ? 32'hxxxx_xxxx : mem_word(imem_addr);

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .id_jump        (id_jump),
    .id_jump_target (id_jump_target),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},        pc,             m_pc);
    chk({tag, ".imem_addr"}, imem_addr,      m_pc);
    chk({tag, ".instr"},     if_id_instr,    m_instr);
    chk({tag, ".pc_plus4"},  if_id_pc_plus4, m_pp4);
    chk({tag, ".valid"},     {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".count"},     fetch_count,    m_cnt);
  endtask

  // One clock: drive inputs, predict the architectural effect, compare after the edge.
  task automatic step(input string tag, input logic rst_n, input logic st, input logic jp,
                      input logic [31:0] jt, input logic ex, input logic [31:0] et);
    logic [31:0] n_pc, n_instr, n_pp4, n_cnt;
    logic        n_valid;
    reset = rst_n; stall = st; id_jump = jp; id_jump_target = jt;
    ex_redirect = ex; ex_target = et;
    #1;
    chk({tag, ".addr_pre"}, imem_addr, m_pc);
    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid; n_cnt = m_cnt;
    if (!rst_n) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0; n_cnt = 32'h0;
    end else if (ex) begin
      n_pc = {et[31:2], 2'b00}; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (jp) begin
      n_pc = {jt[31:2], 2'b00}; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
    end else begin
      n_instr = mem_word(m_pc); n_pp4 = m_pc + 32'd4; n_pc = m_pc + 32'd4;
      n_valid = 1'b1; n_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid; m_cnt = n_cnt;
    chk_all(tag);
  endtask

  initial begin
    // First reset edge defines every output.
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    chk_all("reset");

    // Three free-running fetches from 0x0, 0x4, 0x8.
    step("free0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("free1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("free2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("free.pc_is_c",  pc, 32'h0000_000C);
    chk("free.pp4_is_c", if_id_pc_plus4, 32'h0000_000C);
    chk("free.count_3",  fetch_count, 32'd3);

    // ID jump to 0x10 squashes the sequential fetch.
    step("jump", 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    chk("jump.pc_10", pc, 32'h10);
    step("after_jump", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("after_jump.pp4", if_id_pc_plus4, 32'h14);

    // Stall with a pending jump: hold for two cycles, then the jump is taken.
    step("stall0", 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    step("stall_rel", 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("stall_rel.pc_40", pc, 32'h40);

    // EX redirect beats stall and jump; memory returns X but must not leak.
    mem_x = 1'b1;
    step("exr", 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h2C);
    mem_x = 1'b0;
    chk("exr.pc_2c", pc, 32'h2C);

    // Target alignment.
    step("align", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h31);
    chk("align.pc_30", pc, 32'h30);
    step("align_j", 1'b1, 1'b0, 1'b1, 32'h57, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step("to_top", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap.pc_0",  pc, 32'h0);
    chk("wrap.pp4_0", if_id_pc_plus4, 32'h0);

    // Reset during a redirect discards the redirect.
    step("pre_rst", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("rst_exr", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("rst_exr.count_0", fetch_count, 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_st, r_jp, r_ex;
      logic [31:0] r_jt, r_et;
      r_rst = ($urandom_range(0, 99) >= 3);
      r_st  = ($urandom_range(0, 99) < 25);
      r_jp  = ($urandom_range(0, 99) < 20);
      r_ex  = ($urandom_range(0, 99) < 12);
      r_jt  = $urandom;
      r_et  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step("rand", r_rst, r_st, r_jp, r_jt, r_ex, r_et);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory.
- Owns the PC register, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register.
- Applies stall, ID-stage jump redirects (j/jal) and EX-stage redirects (taken beq/bne, jr).
- Provides a fetched-instruction counter for the UART debug peripheral.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
NOP_WORD, 32'h0000_0000, word injected into IF/ID on a flush (sll $0,$0,0)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  hazard unit load-use stall: hold PC and IF/ID
id_jump  input  1  ID stage decoded j/jal
id_jump_target  input  32  jump target computed in ID
ex_redirect  input  1  EX stage: branch taken or jr
ex_target  input  32  branch/jr target from EX
imem_addr  output  32  address to instruction memory; equals pc (combinational)
imem_instr  input  32  instruction word returned combinationally by memory
pc  output  32  current PC register
if_id_instr  output  32  IF/ID registered instruction
if_id_pc_plus4  output  32  IF/ID registered PC+4 (link value for jal, branch base)
if_id_valid  output  1  1 = IF/ID holds a real fetched instruction, 0 = bubble
fetch_count  output  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (reset==0 at the clock edge) sets pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0 and fetch_count=0.
- Reset overrides every other input, including mid-redirect and mid-stall.
- imem_addr=pc with zero latency. The instruction captured into IF/ID is available one cycle after its address.
- pc_plus4 = pc + 4, computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Targets: bits [1:0] of id_jump_target and ex_target are forced to 0 before loading the PC.
- Per-edge priority, highest first:
  1. reset.
  2. ex_redirect: pc<=ex_target; IF/ID <= {NOP_WORD, 0, valid=0}. This overrides stall and id_jump. The instruction currently in ID is also squashed externally by the hazard unit.
  3. stall: pc and IF/ID hold their values. id_jump is ignored while stall=1, because the ID instruction is not advancing; it is re-presented once the stall clears.
  4. id_jump: pc<=id_jump_target; IF/ID <= {NOP_WORD, 0, valid=0}. The sequential instruction fetched behind the jump is squashed; there are no delay slots.
  5. Otherwise: pc<=pc_plus4; IF/ID <= {imem_instr, pc_plus4, valid=1}.
- fetch_count increments by 1, wrapping at 2^32, only on a cycle that takes case 5.
- Flush cycles, stall cycles and reset do not count.
- No internal states beyond the registers above; the stage is a single-state pipeline with priority-muxed next-state.
- Every output is defined from the first reset edge. No X is propagated from imem_instr during a flush.

Decomposition:
- Shared package holds NOP_WORD, RESET_PC default, PC_STEP=4 and the target alignment mask 32'hFFFF_FFFC.
- These are also used by the decode and branch units.
- One natural sub-module: if_id_register, holding instr, pc_plus4 and valid, with load, hold and flush controls.
- PC register, next-PC mux and counter stay in the top module.

Test Plan:
- Reset then 3 free-running cycles, no stall or redirect: imem_addr sequence 0x0,0x4,0x8; pc=0xC; if_id_pc_plus4=0xC; if_id_valid=1; fetch_count=3.
- id_jump=1 with target 0x10 while pc=0xC: next pc=0x10; if_id_instr=0; if_id_valid=0; fetch_count unchanged; the following cycle fetches from 0x10.
- stall=1 for 2 cycles with id_jump=1: pc and IF/ID unchanged for both cycles. After the stall drops, the jump is taken on the next edge.
- ex_redirect=1 (target 0x2C), stall=1 and id_jump=1 together: pc=0x2C; IF/ID flushed; valid=0.
- ex_target=0x31: pc=0x30.
- pc forced to 0xFFFFFFFC via redirect, then a free cycle: pc wraps to 0x0; if_id_pc_plus4=0x0.
- reset=0 asserted during an ex_redirect cycle: pc=RESET_PC; all IF/ID fields and fetch_count cleared. The redirect is discarded.
